// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the counter family.
// Direction/mode constants and a width helper for prescalers.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Enable-gated prescaler: tick on every PRESCALE-th enabled cycle.
// tick is combinational so the consumer steps on the same edge.
module clk_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW =
    (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescale, load/clear,
// wrap-or-saturate and terminal-count/overflow flags.
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam bit SAT = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] r_value;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_tick;
  logic             w_do_clr;
  logic             w_do_ld;
  logic             w_do_step;
  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_ld_val;
  logic [WIDTH-1:0] w_nxt_value;
  logic             w_nxt_wrap;
  logic             w_nxt_ovf;

  clk_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clear | load),
    .tick    (w_tick)
  );

  // Mutually exclusive actions encode clear > load > step.
  assign w_do_clr  = clear;
  assign w_do_ld   = load & ~clear;
  assign w_do_step = w_tick & ~load & ~clear;

  assign w_at_top = (r_value == MAXV);
  assign w_at_bot = (r_value == '0);
  assign w_ld_val = (load_val > MAXV) ? MAXV : load_val;

  always_comb begin
    w_nxt_value = r_value;
    w_nxt_wrap  = 1'b0;
    w_nxt_ovf   = r_ovf;
    unique case (1'b1)
      w_do_clr: begin
        w_nxt_value = '0;
        w_nxt_ovf   = 1'b0;
      end
      w_do_ld: begin
        w_nxt_value = w_ld_val;
      end
      w_do_step: begin
        if (up_dn == DIR_UP) begin
          if (w_at_top) begin
            w_nxt_wrap = 1'b1;
            w_nxt_ovf  = 1'b1;
            if (!SAT) w_nxt_value = '0;
          end else begin
            w_nxt_value = r_value + WIDTH'(1);
          end
        end else begin
          if (w_at_bot) begin
            w_nxt_wrap = 1'b1;
            w_nxt_ovf  = 1'b1;
            if (!SAT) w_nxt_value = MAXV;
          end else begin
            w_nxt_value = r_value - WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_value <= w_nxt_value;
      r_wrap  <= w_nxt_wrap;
      r_ovf   <= w_nxt_ovf;
    end
  end

  assign value = r_value;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;
  assign tc    = (up_dn == DIR_DN) ? w_at_bot : w_at_top;

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the team's free-running 8-bit counter.
- Adds configurable width, modulus, up/down direction, synchronous load/clear, prescaled stepping, wrap-or-saturate mode, and terminal-count/overflow flags.
- Serves as the standard timebase/event counter for later blocks and benches.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MODULUS, 256, count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- PRESCALE, 1, number of enabled clk cycles per count step (1..65535); 1 = step every enabled cycle.
- SATURATE, 0, 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high; sampled on the clk rising edge.
- en, input, 1, count enable; gates both the prescaler and the count.
- up_dn, input, 1, 1 = count up, 0 = count down; sampled on each step.
- load, input, 1, synchronous load of load_val.
- load_val, input, WIDTH, value to load.
- clear, input, 1, synchronous clear to 0.
- value, output, WIDTH, registered count.
- tc, output, 1, combinational: value at the terminal bound for the current direction (MODULUS-1 when counting up, 0 when counting down).
- wrap, output, 1, registered one-cycle pulse on wrap or on a blocked saturating step.
- ovf, output, 1, sticky flag; set together with wrap; cleared only by reset or clear.

Behaviour:
- Reset (synchronous): value=0, wrap=0, ovf=0, prescaler count=0. tc follows value/up_dn combinationally (after reset, tc=1 if up_dn=0).
- Per-edge priority: reset > clear > load > step > hold.
- clear:
  - value=0, ovf=0, wrap=0, prescaler=0.
  - Overrides load and step in the same cycle.
- load:
  - value = min(load_val, MODULUS-1); prescaler restarts at 0; wrap=0; ovf unchanged.
  - load works regardless of en.
- step:
  - Occurs when en=1 and the prescaler is at PRESCALE-1 (every en cycle when PRESCALE=1).
  - Prescaler counts en cycles 0..PRESCALE-1, then wraps to 0; it holds while en=0.
- Up step:
  - value<MODULUS-1: value+1.
  - value==MODULUS-1 and SATURATE=0: value=0, wrap=1, ovf=1.
  - value==MODULUS-1 and SATURATE=1: value holds, wrap=1, ovf=1.
- Down step:
  - value>0: value-1.
  - value==0 and SATURATE=0: value=MODULUS-1, wrap=1, ovf=1.
  - value==0 and SATURATE=1: value holds, wrap=1, ovf=1.
- wrap: high exactly one cycle after the edge that caused it; low on every other edge, including repeated saturated holds that do not step.
- Latency: value updates on the edge where the step, load or clear is sampled. No pipeline.
- Direction change: up_dn may change on any cycle; it takes effect on the next step and does not reset the prescaler.
- Arithmetic: all compares in WIDTH bits; no intermediate overflow beyond WIDTH. When MODULUS=2^WIDTH, the up wrap is the natural rollover.
- en=0: value, wrap(=0), ovf and prescaler hold; load and clear still act.
- Reset or clear mid-prescale: prescaler goes to 0; the next step comes PRESCALE en-cycles later.

Decomposition:
- Shared package (counter_pkg): direction encodings DIR_UP=1, DIR_DN=0; a MODE_WRAP/MODE_SAT constant pair; a helper function clog2 for prescaler width.
- One sub-module, clk_prescaler:
  - Parameter: PRESCALE.
  - Inputs: clk, reset, en, restart.
  - Output: tick (combinational; en && cnt==PRESCALE-1).
  - Reused by later timer blocks.

Test Plan:
- Reset sequencing: pulse reset for 11 ns mid-count with WIDTH=8, MODULUS=256, PRESCALE=1, en=1, up -> value=0 on the sampled edge, then 1,2,3 on the following edges; ovf=0.
- Up wrap: MODULUS=10, load 9, en=1, up -> next value=0, wrap=1 for one cycle, ovf=1 and stays 1; tc=1 while value=9.
- Down saturate: SATURATE=1, MODULUS=10, value=1, down -> value 0, then holds 0; wrap pulses on each blocked step; ovf=1; tc=1.
- Prescale: PRESCALE=4, en=1 for 12 cycles from value=0 -> value=3. Drop en for 5 cycles mid-run -> value holds and the step timing resumes without loss.
- Load clamp and priority: MODULUS=10, load_val=15 -> value=9. Assert clear+load+step together -> value=0, ovf=0.
- Direction change at the bound: value=0, up step -> 1; switch to down on the next step -> 0, then 9 with wrap=1.
